// File: rtl/dmem_pkg.sv
// Shared types and sizing for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH = 1024;
    localparam int unsigned DMEM_AW    = 10;
    localparam int unsigned DMEM_LAT_W = 4;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT,
        DONE
    } dmem_state_t;

    // WAIT counts down to zero, so a load needs LATENCY-2 extra WAIT cycles.
    function automatic logic [DMEM_LAT_W-1:0] lat_load(input int unsigned lat);
        if (lat >= 2) begin
            return DMEM_LAT_W'(lat - 2);
        end
        return '0;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store handshake between the execute stage (master) and the data memory (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic               m_inp_rdy;
    logic [DMEM_AW-1:0] a;
    logic [3:0]         wen;
    logic [31:0]        wd;
    logic               m_otp_rdy;
    logic [31:0]        rd;
    logic               m_busy;

    modport master (
        output m_inp_rdy, a, wen, wd,
        input  m_otp_rdy, rd, m_busy
    );

    modport slave (
        input  m_inp_rdy, a, wen, wd,
        output m_otp_rdy, rd, m_busy
    );

endinterface

// File: rtl/dmem_array.sv
// 1024x32 storage with byte-lane write enables and a registered read port.
module dmem_array
    import dmem_pkg::*;
(
    input  logic               clk,
    input  logic [DMEM_AW-1:0] addr_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        wdata_i,
    input  logic               re_i,
    output logic [31:0]        rdata_o
);

    logic [31:0] mem_q [DMEM_DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stores commit immediately, loads return after LATENCY cycles.
// Optional power-up zero sweep of the array when DMEM_CLEAR_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = DMEM_DEPTH
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be 1..15");
    end
    if (DEPTH != DMEM_DEPTH) begin : g_bad_depth
        $error("dmem_responder: DEPTH is fixed at 1024");
    end

`ifdef DMEM_CLEAR_EN
    localparam dmem_state_t RST_STATE = CLEAR;
    logic [DMEM_AW-1:0] sweep_q, sweep_d;
`else
    localparam dmem_state_t RST_STATE = IDLE;
`endif

    dmem_state_t           state_q, state_d;
    logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]           rd_q, rd_d;

    logic [DMEM_AW-1:0]    arr_addr;
    logic [3:0]            arr_be;
    logic [31:0]           arr_wdata;
    logic                  arr_re;
    logic [31:0]           arr_rdata;
    logic                  otp_rdy;

    dmem_array u_array (
        .clk     (clk),
        .addr_i  (arr_addr),
        .be_i    (arr_be),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            rd_q    <= '0;
`ifdef DMEM_CLEAR_EN
            sweep_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
`ifdef DMEM_CLEAR_EN
            sweep_q <= sweep_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        arr_addr  = bus.a;
        arr_be    = '0;
        arr_wdata = bus.wd;
        arr_re    = 1'b0;
        otp_rdy   = 1'b0;
`ifdef DMEM_CLEAR_EN
        sweep_d   = sweep_q;
`endif

        unique case (state_q)
            CLEAR: begin
`ifdef DMEM_CLEAR_EN
                arr_addr  = sweep_q;
                arr_be    = '1;
                arr_wdata = '0;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == DMEM_AW'(DMEM_DEPTH - 1)) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            IDLE: begin
                if (bus.m_inp_rdy) begin
                    if (bus.wen != '0) begin
                        arr_be = bus.wen;
                    end else begin
                        arr_re = 1'b1;
                        if (LATENCY == 1) begin
                            state_d = DONE;
                        end else begin
                            cnt_d   = lat_load(LATENCY);
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                otp_rdy = 1'b1;
                rd_d    = arr_rdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The array read register already holds the word during DONE; rd_q keeps it afterwards.
    assign bus.m_otp_rdy = otp_rdy;
    assign bus.rd        = (state_q == DONE) ? arr_rdata : rd_q;
    assign bus.m_busy    = (state_q != IDLE);

endmodule
